// File: rtl/imm_alu_sequencer_pkg.sv
// Shared definitions for the OP-IMM sequencer slice.
//   OPCODE_OP_IMM : major opcode of I-type ALU instructions
//   ALU_*         : 5-bit codes understood by the shared ALU
//   seq_state_t   : sequencer FSM state type
package processor_defines;

  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

  // Low three bits follow funct3; bit 3 distinguishes SRA from SRL.
  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SLL  = 5'b00001;
  localparam logic [4:0] ALU_SLT  = 5'b00010;
  localparam logic [4:0] ALU_SLTU = 5'b00011;
  localparam logic [4:0] ALU_XOR  = 5'b00100;
  localparam logic [4:0] ALU_SRL  = 5'b00101;
  localparam logic [4:0] ALU_OR   = 5'b00110;
  localparam logic [4:0] ALU_AND  = 5'b00111;
  localparam logic [4:0] ALU_SRA  = 5'b01101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_READ,
    S_EXEC,
    S_WB,
    S_TRAP,
    S_DRAIN
  } seq_state_t;

endpackage

// File: rtl/imm_alu_sequencer_if.sv
// Bus between the sequencer and the shared ALU.
//   alu_start   : one-cycle issue pulse (sequencer -> ALU)
//   alu_control : ALU op code (sequencer -> ALU)
//   alu_op_a/b  : operands (sequencer -> ALU)
//   alu_done    : result valid (ALU -> sequencer)
//   alu_result  : result (ALU -> sequencer)
interface imm_alu_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            alu_start;
  logic [4:0]      alu_control;
  logic [XLEN-1:0] alu_op_a;
  logic [XLEN-1:0] alu_op_b;
  logic            alu_done;
  logic [XLEN-1:0] alu_result;

  modport master (
    output alu_start, alu_control, alu_op_a, alu_op_b,
    input  alu_done, alu_result
  );

  modport slave (
    input  alu_start, alu_control, alu_op_a, alu_op_b,
    output alu_done, alu_result
  );
endinterface

// File: rtl/imm_alu_sequencer_op_decode.sv
// Combinational OP-IMM decode.
//   opcode, funct3, imm : instruction fields
//   alu_control         : shared ALU op code
//   legal               : instruction is a supported OP-IMM encoding
//   imm_b               : operand-b value (shamt for shifts, sign-extended imm otherwise)
module imm_alu_op_decode
  import processor_defines::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [11:0]     imm,
  output logic [4:0]      alu_control,
  output logic            legal,
  output logic [XLEN-1:0] imm_b
);

  logic [6:0] imm_hi;
  assign imm_hi = imm[11:5];

  always_comb begin
    legal       = (opcode == OPCODE_OP_IMM);
    alu_control = ALU_ADD;
    imm_b       = {{(XLEN-12){imm[11]}}, imm};
    case (funct3)
      3'b000: alu_control = ALU_ADD;
      3'b001: begin
        alu_control = ALU_SLL;
        imm_b       = {{(XLEN-5){1'b0}}, imm[4:0]};
        if (imm_hi != 7'b0000000) legal = 1'b0;
      end
      3'b010: alu_control = ALU_SLT;
      3'b011: alu_control = ALU_SLTU;
      3'b100: alu_control = ALU_XOR;
      3'b101: begin
        alu_control = imm[10] ? ALU_SRA : ALU_SRL;
        imm_b       = {{(XLEN-5){1'b0}}, imm[4:0]};
        if (imm_hi != 7'b0000000 && imm_hi != 7'b0100000) legal = 1'b0;
      end
      3'b110: alu_control = ALU_OR;
      3'b111: alu_control = ALU_AND;
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/imm_alu_sequencer.sv
// Multi-cycle sequencer for RISC-V OP-IMM instructions.
//   clk, rst_n          : clock, synchronous active-low reset
//   instr_valid/ready   : instruction handshake, instr is the word
//   flush               : abort current instruction without writeback
//   rf_raddr / rf_rdata : registered register-file read port
//   alu                 : shared ALU bus (master side)
//   rf_we/waddr/wdata   : register-file write port
//   illegal_instr       : pulse on a rejected instruction
//   busy                : sequencer not idle
//   retired_count       : wrapping count of retired instructions
module imm_alu_sequencer
  import processor_defines::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  input  logic [31:0]         instr,
  output logic                instr_ready,
  input  logic                flush,
  output logic [4:0]          rf_raddr,
  input  logic [XLEN-1:0]     rf_rdata,
  imm_alu_sequencer_if.master alu,
  output logic                rf_we,
  output logic [4:0]          rf_waddr,
  output logic [XLEN-1:0]     rf_wdata,
  output logic                illegal_instr,
  output logic                busy,
  output logic [31:0]         retired_count
);

  seq_state_t      state_q, state_d;
  logic [31:0]     instr_q;
  logic [4:0]      ctrl_q;
  logic [XLEN-1:0] op_a_q, op_b_q, result_q;
  logic            start_q;
  logic [31:0]     retired_q;

  logic [4:0]      dec_ctrl;
  logic            dec_legal;
  logic [XLEN-1:0] dec_imm_b;
  logic [4:0]      rd;
  logic            retire;

  assign rd = instr_q[11:7];

  imm_alu_op_decode #(.XLEN(XLEN)) u_decode (
    .opcode      (instr_q[6:0]),
    .funct3      (instr_q[14:12]),
    .imm         (instr_q[31:20]),
    .alu_control (dec_ctrl),
    .legal       (dec_legal),
    .imm_b       (dec_imm_b)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (instr_valid) state_d = S_DECODE;
      S_DECODE: state_d = flush ? S_IDLE : (dec_legal ? S_READ : S_TRAP);
      S_READ:   state_d = flush ? S_IDLE : S_EXEC;
      S_EXEC: begin
        // A result arriving with flush is simply dropped; no drain needed.
        if (flush)             state_d = alu.alu_done ? S_IDLE : S_DRAIN;
        else if (alu.alu_done) state_d = S_WB;
      end
      S_WB:     state_d = S_IDLE;
      S_TRAP:   state_d = S_IDLE;
      S_DRAIN:  if (alu.alu_done) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    instr_ready   = (state_q == S_IDLE);
    busy          = (state_q != S_IDLE);
    rf_raddr      = (state_q == S_DECODE) ? instr_q[19:15] : '0;
    retire        = (state_q == S_WB) && !flush;
    rf_we         = retire && (rd != 5'd0);
    rf_waddr      = (state_q == S_WB) ? rd : '0;
    rf_wdata      = (state_q == S_WB) ? result_q : '0;
    illegal_instr = (state_q == S_TRAP) && !flush;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q   <= '0;
      ctrl_q    <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      result_q  <= '0;
      start_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      // Issue pulse is registered so it lands in the first EXEC cycle only.
      start_q <= (state_q == S_READ) && (state_d == S_EXEC);
      if (state_q == S_IDLE && instr_valid) instr_q <= instr;
      if (state_q == S_READ && state_d == S_EXEC) begin
        ctrl_q <= dec_ctrl;
        op_a_q <= rf_rdata;
        op_b_q <= dec_imm_b;
      end
      if (state_q == S_EXEC && state_d == S_WB) result_q <= alu.alu_result;
      if (retire) retired_q <= retired_q + 32'd1;
    end
  end

  assign alu.alu_start   = start_q;
  assign alu.alu_control = ctrl_q;
  assign alu.alu_op_a    = op_a_q;
  assign alu.alu_op_b    = op_b_q;
  assign retired_count   = retired_q;

endmodule

// File: tb/tb_imm_alu_sequencer.sv
module tb_imm_alu_sequencer;
  import processor_defines::*;

  localparam int unsigned XLEN = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        flush = 1'b0;
  logic        instr_ready;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        illegal_instr;
  logic        busy;
  logic [31:0] retired_count;

  imm_alu_sequencer_if #(.XLEN(XLEN)) alu_bus ();

  imm_alu_sequencer #(.XLEN(XLEN)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_ready   (instr_ready),
    .flush         (flush),
    .rf_raddr      (rf_raddr),
    .rf_rdata      (rf_rdata),
    .alu           (alu_bus),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .illegal_instr (illegal_instr),
    .busy          (busy),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  // Reference register file: contents change only when the model retires.
  logic [31:0] rf_mem [32];
  always @(posedge clk) rf_rdata <= rf_mem[rf_raddr];

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_retired = '0;
  logic [4:0]  ctrl_tab [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [31:0] w);
    logic [6:0] hi;
    hi = w[31:25];
    if (w[6:0] != 7'b0010011) return 1'b0;
    if (w[14:12] == 3'd1) return hi == 7'h00;
    if (w[14:12] == 3'd5) return (hi == 7'h00) || (hi == 7'h20);
    return 1'b1;
  endfunction

  function automatic logic [4:0] exp_ctrl(input logic [31:0] w);
    if (w[14:12] == 3'd5 && w[30]) return ALU_SRA;
    return ctrl_tab[w[14:12]];
  endfunction

  function automatic logic [31:0] exp_opb(input logic [31:0] w);
    logic [31:0] v;
    if (w[14:12] == 3'd1 || w[14:12] == 3'd5) v = {27'd0, w[24:20]};
    else                                      v = {{20{w[31]}}, w[31:20]};
    return v;
  endfunction

  // Architectural result of the instruction, computed from the ISA rules.
  function automatic logic [31:0] exp_result(input logic [31:0] w, input logic [31:0] a);
    logic [31:0] b, r;
    int unsigned sh;
    b  = exp_opb(w);
    sh = int'(w[24:20]);
    case (w[14:12])
      3'd0: r = a + b;
      3'd1: r = a << sh;
      3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: r = (a < b) ? 32'd1 : 32'd0;
      3'd4: r = a ^ b;
      3'd5: begin
        if (w[30]) r = $signed(a) >>> sh;
        else       r = a >> sh;
      end
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  task automatic accept(input logic [31:0] w, input string tag);
    int unsigned guard;
    guard = 0;
    while (!instr_ready && guard < 50) begin
      step();
      guard++;
    end
    chk1({tag, " ready_before_accept"}, instr_ready, 1'b1);
    instr_valid = 1'b1;
    instr       = w;
    step();
    instr_valid = 1'b0;
    instr       = $urandom();
  endtask

  task automatic run_instr(input logic [31:0] w, input int unsigned k, input string tag);
    logic [4:0]  rs1, rd;
    logic [31:0] a, res;
    rs1 = w[19:15];
    rd  = w[11:7];
    a   = (rs1 == 5'd0) ? 32'd0 : rf_mem[rs1];
    res = exp_result(w, a);
    accept(w, tag);
    chk({tag, " raddr"}, 32'(rf_raddr), 32'(rs1));
    chk1({tag, " busy"}, busy, 1'b1);
    if (!is_legal(w)) begin
      step();
      chk1({tag, " illegal_pulse"}, illegal_instr, 1'b1);
      chk1({tag, " no_start"}, alu_bus.alu_start, 1'b0);
      chk1({tag, " no_we"}, rf_we, 1'b0);
      step();
      chk1({tag, " illegal_clear"}, illegal_instr, 1'b0);
      chk1({tag, " ready_after_trap"}, instr_ready, 1'b1);
      chk({tag, " count_unchanged"}, retired_count, exp_retired);
    end else begin
      step();
      chk1({tag, " no_illegal"}, illegal_instr, 1'b0);
      step();
      chk1({tag, " start"}, alu_bus.alu_start, 1'b1);
      chk({tag, " control"}, 32'(alu_bus.alu_control), 32'(exp_ctrl(w)));
      chk({tag, " op_a"}, alu_bus.alu_op_a, a);
      chk({tag, " op_b"}, alu_bus.alu_op_b, exp_opb(w));
      for (int unsigned i = 0; i < k; i++) begin
        step();
        chk1({tag, " start_once"}, alu_bus.alu_start, 1'b0);
        chk({tag, " op_b_stable"}, alu_bus.alu_op_b, exp_opb(w));
        chk1({tag, " we_wait"}, rf_we, 1'b0);
      end
      alu_bus.alu_done   = 1'b1;
      alu_bus.alu_result = res;
      step();
      alu_bus.alu_done   = 1'b0;
      alu_bus.alu_result = $urandom();
      chk1({tag, " we"}, rf_we, rd != 5'd0);
      chk({tag, " waddr"}, 32'(rf_waddr), 32'(rd));
      chk({tag, " wdata"}, rf_wdata, res);
      if (rd != 5'd0) rf_mem[rd] = res;
      exp_retired = exp_retired + 32'd1;
      step();
      chk1({tag, " ready_after_wb"}, instr_ready, 1'b1);
      chk1({tag, " we_pulse"}, rf_we, 1'b0);
      chk({tag, " count"}, retired_count, exp_retired);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [11:0] imm;
    logic [2:0]  f3;
    logic [4:0]  rs1, rd;
    logic [6:0]  opc;

    ctrl_tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    for (int i = 0; i < 32; i++) rf_mem[i] = (i == 0) ? 32'd0 : $urandom();
    rf_mem[1] = 32'h0000_0010;
    alu_bus.alu_done   = 1'b0;
    alu_bus.alu_result = '0;

    // Reset values
    rst_n = 1'b0;
    step();
    step();
    chk1("rst instr_ready", instr_ready, 1'b1);
    chk1("rst busy", busy, 1'b0);
    chk1("rst alu_start", alu_bus.alu_start, 1'b0);
    chk1("rst rf_we", rf_we, 1'b0);
    chk1("rst illegal", illegal_instr, 1'b0);
    chk("rst count", retired_count, 32'd0);
    chk("rst op_a", alu_bus.alu_op_a, 32'd0);
    chk("rst control", 32'(alu_bus.alu_control), 32'd0);
    rst_n = 1'b1;
    step();

    // ADDI x5,x1,-1 with k=1
    run_instr({12'hFFF, 5'd1, 3'b000, 5'd5, 7'b0010011}, 1, "addi");
    chk("addi x5 model", rf_mem[5], 32'h0000_000F);
    // SRAI x3,x2,4
    run_instr({7'b0100000, 5'd4, 5'd2, 3'b101, 5'd3, 7'b0010011}, 2, "srai");
    // SLLI with nonzero imm[11:5]
    run_instr({7'b0000001, 5'd3, 5'd2, 3'b001, 5'd4, 7'b0010011}, 1, "slli_bad");
    // R-type opcode
    run_instr({7'b0000000, 5'd3, 5'd2, 3'b000, 5'd4, 7'b0110011}, 1, "rtype");
    // ADDI x0,x0,5
    run_instr({12'd5, 5'd0, 3'b000, 5'd0, 7'b0010011}, 1, "addi_x0");

    // Flush in EXEC, alu_done three cycles later
    accept({12'd7, 5'd1, 3'b000, 5'd6, 7'b0010011}, "fl_exec");
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk1("fl_exec drain busy", busy, 1'b1);
    step();
    chk1("fl_exec drain ready", instr_ready, 1'b0);
    step();
    chk1("fl_exec drain we", rf_we, 1'b0);
    alu_bus.alu_done = 1'b1;
    #1;
    chk1("fl_exec ready_with_done", instr_ready, 1'b0);
    step();
    alu_bus.alu_done = 1'b0;
    chk1("fl_exec ready_after_done", instr_ready, 1'b1);
    chk1("fl_exec no_we", rf_we, 1'b0);
    chk("fl_exec count", retired_count, exp_retired);
    run_instr({12'h123, 5'd1, 3'b110, 5'd7, 7'b0010011}, 1, "after_flush");

    // Flush and alu_done in the same EXEC cycle
    accept({12'd9, 5'd1, 3'b000, 5'd8, 7'b0010011}, "fl_done");
    step();
    step();
    step();
    flush = 1'b1;
    alu_bus.alu_done = 1'b1;
    step();
    flush = 1'b0;
    alu_bus.alu_done = 1'b0;
    chk1("fl_done ready", instr_ready, 1'b1);
    chk1("fl_done no_we", rf_we, 1'b0);
    chk("fl_done count", retired_count, exp_retired);

    // Flush in DECODE
    accept({12'd1, 5'd1, 3'b000, 5'd9, 7'b0010011}, "fl_dec");
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk1("fl_dec ready", instr_ready, 1'b1);
    step();
    chk1("fl_dec no_start", alu_bus.alu_start, 1'b0);

    // Flush in TRAP suppresses the pulse
    accept({12'd0, 5'd1, 3'b000, 5'd9, 7'b1111111}, "fl_trap");
    step();
    flush = 1'b1;
    #1;
    chk1("fl_trap no_illegal", illegal_instr, 1'b0);
    step();
    flush = 1'b0;
    chk1("fl_trap ready", instr_ready, 1'b1);

    // Flush in WB suppresses writeback and retirement
    accept({12'd3, 5'd1, 3'b000, 5'd10, 7'b0010011}, "fl_wb");
    step();
    step();
    step();
    alu_bus.alu_done = 1'b1;
    step();
    alu_bus.alu_done = 1'b0;
    flush = 1'b1;
    #1;
    chk1("fl_wb no_we", rf_we, 1'b0);
    step();
    flush = 1'b0;
    chk1("fl_wb ready", instr_ready, 1'b1);
    chk("fl_wb count", retired_count, exp_retired);

    // alu_done while idle is ignored
    alu_bus.alu_done = 1'b1;
    step();
    alu_bus.alu_done = 1'b0;
    chk1("stray_done idle", busy, 1'b0);
    chk1("stray_done no_we", rf_we, 1'b0);

    // Randomized instructions
    for (int n = 0; n < 30; n++) begin
      imm = 12'($urandom());
      f3  = 3'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 31));
      rd  = 5'($urandom_range(0, 31));
      opc = OPCODE_OP_IMM;
      if (f3 == 3'd1 && $urandom_range(0, 3) != 0) imm[11:5] = 7'h00;
      if (f3 == 3'd5 && $urandom_range(0, 3) != 0) imm[11:5] = $urandom_range(0, 1) != 0 ? 7'h20 : 7'h00;
      if ($urandom_range(0, 7) == 0) opc = 7'($urandom());
      w = {imm, rs1, f3, rd, opc};
      run_instr(w, $urandom_range(1, 4), "rand");
    end

    // Reset during WB abandons the writeback
    accept({12'd2, 5'd1, 3'b000, 5'd11, 7'b0010011}, "rst_wb");
    step();
    step();
    step();
    alu_bus.alu_done = 1'b1;
    step();
    alu_bus.alu_done = 1'b0;
    rst_n = 1'b0;
    step();
    chk1("rst_wb we", rf_we, 1'b0);
    chk1("rst_wb ready", instr_ready, 1'b1);
    chk1("rst_wb busy", busy, 1'b0);
    chk("rst_wb wdata", rf_wdata, 32'd0);
    chk("rst_wb op_b", alu_bus.alu_op_b, 32'd0);
    chk("rst_wb count", retired_count, 32'd0);
    rst_n = 1'b1;
    exp_retired = '0;
    step();

    // Counter wrap
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    exp_retired = 32'hFFFF_FFFF;
    chk("wrap preload", retired_count, 32'hFFFF_FFFF);
    run_instr({12'h00F, 5'd1, 3'b111, 5'd12, 7'b0010011}, 1, "wrap");
    chk("wrap zero", retired_count, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_alu_sequencer.md
# imm_alu_sequencer

Multi-cycle sequencer for RISC-V OP-IMM (I-type ALU) instructions. It accepts one instruction at a time over a valid/ready handshake, decodes funct3/imm into a 5-bit ALU control code, and reads rs1 from the register file. It then issues the operation to the shared ALU, waits for completion and writes the result back to rd. It sits between the instruction buffer and the ALU/register-file datapath.

## Interface
- XLEN, 32, datapath width
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- instr_valid  in  1  instruction word present
- instr  in  32  instruction word
- instr_ready  out  1  sequencer can accept; high only in IDLE
- flush  in  1  abort current instruction, no writeback
- rf_raddr  out  5  register-file read address (registered read, data next cycle)
- rf_rdata  in  XLEN  register-file read data
- alu_start  out  1  one-cycle issue pulse
- alu_control  out  5  ALU op code, stable from alu_start until alu_done
- alu_op_a, alu_op_b  out  XLEN  operands, stable from alu_start until alu_done
- alu_done  in  1  ALU result valid, earliest one cycle after alu_start
- alu_result  in  XLEN  ALU result
- rf_we  out  1  write-enable pulse
- rf_waddr  out  5  write address
- rf_wdata  out  XLEN  write data
- illegal_instr  out  1  one-cycle pulse on rejected instruction
- busy  out  1  state != IDLE
- retired_count  out  32  count of completed writebacks/rd==x0 retirements, wraps

## Operation
- States: IDLE, DECODE, READ, EXEC, WB, TRAP, DRAIN.
- IDLE: instr_ready=1. On instr_valid&&instr_ready, latch instr and go to DECODE.
- DECODE: drive rf_raddr=instr[19:15]. Check the opcode and the funct3/imm legality.
  - Illegal means one of: opcode != 7'b0010011; funct3=001 with imm[11:5]!=0; funct3=101 with imm[11:5] not in {0000000, 0100000}.
  - Illegal goes to TRAP; legal goes to READ.
- Code mapping uses the shared ALU codes: 000 ADDI, 001 SLLI, 010 SLTI, 011 SLTIU, 100 XORI, 101 SRLI/SRAI (selected by imm[10]), 110 ORI, 111 ANDI.
- READ: capture alu_op_a=rf_rdata.
  - Shifts: alu_op_b = zero-extended imm[4:0].
  - All other ops: alu_op_b = sign-extended imm[11:0] to XLEN.
  - Go to EXEC.
- EXEC: alu_start=1 in the first EXEC cycle only. Wait for alu_done, then capture alu_result and go to WB.
- WB:
  - rf_we=1 for one cycle with rf_waddr=rd and rf_wdata=result.
  - If rd==0, rf_we=0 but the instruction still retires.
  - retired_count increments. Go to IDLE.
- TRAP: illegal_instr=1 for one cycle, no rf_we, no count increment. Go to IDLE.
- flush:
  - flush in DECODE, READ, WB or TRAP goes to IDLE next cycle. Any rf_we or illegal_instr that would have been asserted in that cycle is suppressed.
  - flush in EXEC goes to DRAIN. DRAIN waits for alu_done, discards the result, then goes to IDLE.
  - If alu_done and flush arrive in the same EXEC cycle, go to IDLE and discard the result.
  - flush in IDLE or DRAIN has no effect.
- alu_done outside EXEC/DRAIN is ignored.

## Timing
- Reset values: state=IDLE, instr_ready=1, busy=0, all other outputs 0, retired_count=0. Reset mid-instruction abandons it without writeback.
- Accept at edge T. Then:
  - DECODE at T+1.
  - READ at T+2.
  - alu_start at T+3.
  - With alu_done at T+3+k (k>=1), rf_we is at T+4+k.
  - instr_ready is high again at T+5+k.
- Illegal instruction: illegal_instr at T+2, instr_ready again at T+3.
- Throughput: one instruction in flight. instr is not sampled when instr_ready=0.
- retired_count wraps from 0xFFFFFFFF to 0.

## Structure
- Shared package processor_defines: ALU_* codes, OPCODE_OP_IMM, state enum type.
- Sub-module imm_alu_op_decode: combinational funct3/imm → alu_control and legal flag, plus operand-b immediate formation. Keeps the FSM file sequential-only.

## Test plan
- ADDI x5,x1,-1 with rf_rdata=0x10 and ALU done at k=1: alu_op_b=0xFFFFFFFF, alu_control=ADDI. rf_we at T+5 with waddr=5 and wdata equal to alu_result. retired_count=1.
- SRAI x3,x2,4 (imm[11:5]=0100000): alu_control=SRAI and alu_op_b=4. SLLI with imm[11:5]=0000001: illegal_instr pulse at T+2, no alu_start, no rf_we.
- Opcode 0110011 presented: illegal_instr at T+2. retired_count is unchanged.
- ADDI x0,x0,5: alu_start issued, rf_we stays 0, retired_count increments.
- flush in EXEC with alu_done 3 cycles later: no rf_we, instr_ready stays 0 until the cycle after alu_done. The next instruction then completes normally.
- rst_n low during WB: rf_we=0 next cycle and all outputs at reset values. Also preload retired_count to 0xFFFFFFFF via a run of instructions, or use force in the bench; one retirement wraps it to 0.
